serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder used by serial_adder for each bit step.
module fa (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one result bit per clock, LSB first, WIDTH clocks per add.
// Optional signed-overflow output ovf is enabled with macro SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             fa_sum;
    logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa u_fa (
        .c_out (fa_cout),
        .sum   (fa_sum),
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == ST_RUN) begin
            // Result bits enter from the MSB side so bit 0 lands in place after WIDTH steps.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_DONE;
                c_out_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB position.
                ovf_d   = carry_q ^ fa_cout;
`endif
            end
        end else if (start) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = c_in;
        end else begin
            state_d = ST_IDLE;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), ovf checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       c_in = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Issues one single-cycle start and waits (bounded) for done; returns observed
    // latency in negedge samples after the accepting edge and the busy cycle count.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = av; b = bv; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; c_in = ~ci;
        lat = -1; bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, sum, c_out} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
        end
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h12, 8'hC8};
        logic [7:0] vb [6] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h34, 8'h64};
        logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] es [6] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h46, 8'h2D};
        logic       ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef SERIAL_ADDER_OVF_EN
        logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            do_add(va[i], vb[i], vc[i], lat, bcnt);
            total++;
            if (lat !== 9) begin
                bad++;
                $display("FAIL latency[%0d]: got %0d want 9", i, lat);
            end
            total++;
            if (bcnt !== 8) begin
                bad++;
                $display("FAIL busy_cycles[%0d]: got %0d want 8", i, bcnt);
            end
            total++;
            if (sum !== es[i] || c_out !== ec[i]) begin
                bad++;
                $display("FAIL result[%0d]: got c_out=%b sum=%h want c_out=%b sum=%h", i, c_out, sum, ec[i], es[i]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            total++;
            if (ovf !== eo[i]) begin
                bad++;
                $display("FAIL ovf[%0d]: got %b want %b", i, ovf, eo[i]);
            end
`endif
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== es[i] || c_out !== ec[i]) begin
                bad++;
                $display("FAIL hold[%0d]: got done=%b busy=%b sum=%h c_out=%b want 0 0 %h %b",
                         i, done, busy, sum, c_out, es[i], ec[i]);
            end
            $display("add %h + %h + %b -> c_out=%b sum=%h lat=%0d busy=%0d",
                     va[i], vb[i], vc[i], c_out, sum, lat, bcnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        // start stays high with new operands; must be ignored during RUN
        a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (lat !== 9 || sum !== 8'h30 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d sum=%h c_out=%b want lat=9 sum=30 c_out=0", lat, sum, c_out);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b sum=%h want busy=1 done=0 sum=00", busy, done, sum);
        end
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 9 || sum !== 8'hFF || c_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d sum=%h c_out=%b want lat=9 sum=ff c_out=1", lat, sum, c_out);
        end
        $display("back_to_back: second result c_out=%b sum=%h lat=%0d", c_out, sum, lat);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, seen;
        @(negedge clk);
        a = 8'h55; b = 8'h11; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, sum, c_out} !== 11'd0) begin
            bad++;
            $display("FAIL abort_async: got busy=%b done=%b sum=%h c_out=%b want all 0", busy, done, sum, c_out);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        do_add(8'h03, 8'h04, 1'b0, lat, bcnt);
        total++;
        if (lat !== 9 || sum !== 8'h07 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL after_abort: got lat=%0d sum=%h c_out=%b want lat=9 sum=07 c_out=0", lat, sum, c_out);
        end
        $display("reset_abort: post-reset add 03+04 -> sum=%h lat=%0d", sum, lat);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
